// File: rtl/sram_wbuf_if.sv
// sram_wbuf_if: CPU-side and SRAM-bus-side signals of the posted-write buffer.
interface sram_wbuf_if #(parameter int AW = 8, parameter int DW = 8);
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic cpu_we;
  logic cpu_re;
  logic [DW-1:0] cpu_rdata;
  logic cpu_stall;
  logic breq;
  logic bgrt;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic bus_we;
  logic [DW-1:0] bus_rdata;
  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, bgrt, bus_rdata,
    input cpu_rdata, cpu_stall, breq, bus_addr, bus_wdata, bus_we
  );
  modport slave (
    input cpu_addr, cpu_wdata, cpu_we, cpu_re, bgrt, bus_rdata,
    output cpu_rdata, cpu_stall, breq, bus_addr, bus_wdata, bus_we
  );
endinterface

// File: rtl/sram_wbuf.sv
// sram_wbuf: posted-write FIFO between CPU and SRAM arbiter, draining on grant.
// Store-to-load forwarding is compiled in when WBUF_FWD_EN is defined.
module sram_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW = 8,
  parameter int DW = 8
) (
  input logic clk,
  input logic rst,
  sram_wbuf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [DW-1:0] rdata_q, ld_data, fwd_data;
  logic empty, full, pop, push, hit, bus_ld, ld_done;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  // a drain is suppressed in the reset cycle so discarded entries never reach SRAM
  assign pop = bus.bgrt & !empty & !rst;
  assign push = bus.cpu_we & (!full | pop);
  assign bus_ld = bus.cpu_re & empty & bus.bgrt;
  assign ld_done = bus.cpu_re & (hit | (empty & bus.bgrt));
  assign ld_data = hit ? fwd_data : bus.bus_rdata;
`ifdef WBUF_FWD_EN
  // later slots overwrite earlier ones, so the youngest matching entry wins
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count && mem_addr[head + PW'(i)] == bus.cpu_addr) begin
        hit = 1'b1;
        fwd_data = mem_data[head + PW'(i)];
      end
  end
`else
  assign hit = 1'b0;
  assign fwd_data = '0;
`endif
  assign bus.breq = !empty | bus.cpu_re;
  assign bus.bus_we = pop;
  assign bus.bus_addr = pop ? mem_addr[head] : bus_ld ? bus.cpu_addr : '0;
  assign bus.bus_wdata = pop ? mem_data[head] : '0;
  assign bus.cpu_stall = (bus.cpu_we & !push) | (bus.cpu_re & !ld_done);
  assign bus.cpu_rdata = ld_done ? ld_data : rdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      rdata_q <= '0;
    end else begin
      if (push) begin
        mem_addr[tail] <= bus.cpu_addr;
        mem_data[tail] <= bus.cpu_wdata;
        tail <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (ld_done) rdata_q <= ld_data;
    end
  end
endmodule

// File: tb/tb_sram_wbuf.sv
// tb_sram_wbuf: randomized scoreboard bench; expected loads come from a program-order memory model.
module tb_sram_wbuf;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  sram_wbuf_if #(.AW(8), .DW(8)) ifc();
  sram_wbuf #(.DEPTH(4), .AW(8), .DW(8)) dut (.clk(clk), .rst(rst), .bus(ifc));
  logic [7:0] sram [256] = '{default: 8'h00};
  logic [7:0] prog_mem [256] = '{default: 8'h00};
  logic [15:0] exp_wr [$];
  logic [7:0] exp_ld [$];
  int n_cmp = 0;
  int n_bad = 0;
  int gmode = 0;
  int gp = 60;
  logic poke = 0;
  logic [7:0] poke_a = 0, poke_d = 0;
  assign ifc.bus_rdata = sram[ifc.bus_addr];
  always @(posedge clk)
    if (poke) sram[poke_a] <= poke_d;
    else if (ifc.bus_we) sram[ifc.bus_addr] <= ifc.bus_wdata;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic gbit();
    return gmode == 2 ? 1'b1 : gmode == 1 ? 1'b0 : ($urandom_range(0, 99) < gp);
  endfunction
  task automatic do_store(input logic [7:0] a, input logic [7:0] d, output int waits);
    ifc.cpu_addr = a; ifc.cpu_wdata = d; ifc.cpu_we = 1; ifc.cpu_re = 0;
    exp_wr.push_back({a, d});
    prog_mem[a] = d;
    waits = 0;
    forever begin
      ifc.bgrt = gbit();
      #4;
      if (!ifc.cpu_stall) break;
      if (waits == 200) begin check("store_timeout", 1, 0); break; end
      waits++;
      @(negedge clk);
    end
    @(negedge clk);
    ifc.cpu_we = 0;
  endtask
  task automatic do_load(input logic [7:0] a, output int waits, output logic [7:0] d);
    ifc.cpu_addr = a; ifc.cpu_we = 0; ifc.cpu_re = 1;
    exp_ld.push_back(prog_mem[a]);
    waits = 0;
    d = 0;
    forever begin
      ifc.bgrt = gbit();
      #4;
      if (!ifc.cpu_stall) begin d = ifc.cpu_rdata; break; end
      if (waits == 200) begin check("load_timeout", 1, 0); break; end
      waits++;
      @(negedge clk);
    end
    @(negedge clk);
    ifc.cpu_re = 0;
  endtask
  task automatic idle();
    ifc.cpu_we = 0; ifc.cpu_re = 0;
    ifc.bgrt = gbit();
    @(negedge clk);
  endtask
  initial begin : monitor
    logic [15:0] w;
    forever begin
      @(negedge clk);
      #4;
      if (rst) continue;
      if (ifc.bus_we) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", ifc.bus_addr, w[15:8]);
          check("wr_data", ifc.bus_wdata, w[7:0]);
        end
      end
      if (ifc.cpu_re && !ifc.cpu_stall) begin
        if (exp_ld.size() == 0) check("ld_unexpected", 1, 0);
        else check("ld_data", ifc.cpu_rdata, exp_ld.pop_front());
      end
      if (!ifc.bgrt) check("bus_idle", {ifc.bus_we, ifc.bus_addr, ifc.bus_wdata}, 0);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int wt;
    logic [7:0] d, a;
    ifc.cpu_addr = 0; ifc.cpu_wdata = 0; ifc.cpu_we = 0; ifc.cpu_re = 0; ifc.bgrt = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #4;
    check("rst_breq", ifc.breq, 0);
    check("rst_bus_we", ifc.bus_we, 0);
    check("rst_stall", ifc.cpu_stall, 0);
    check("rst_rdata", ifc.cpu_rdata, 0);
    @(negedge clk);
    // in-order drain of three posted stores
    gmode = 1;
    do_store(8'h10, 8'hA1, wt); check("t2_nostall0", wt, 0);
    do_store(8'h11, 8'hA2, wt); check("t2_nostall1", wt, 0);
    do_store(8'h12, 8'hA3, wt); check("t2_nostall2", wt, 0);
    ifc.bgrt = 0; #4; check("t2_breq", ifc.breq, 1); @(negedge clk);
    gmode = 2;
    repeat (3) idle();
    ifc.bgrt = 0; #4; check("t2_breq_after", ifc.breq, 0); @(negedge clk);
    // full FIFO: stall, then push alongside a pop
    gmode = 1;
    for (int i = 0; i < 4; i++) begin
      do_store(8'(8'h30 + i), 8'(8'h40 + i), wt);
      check("t3_fill", wt, 0);
    end
    ifc.cpu_addr = 8'h35; ifc.cpu_wdata = 8'h55; ifc.cpu_we = 1; ifc.bgrt = 0;
    exp_wr.push_back(16'h3555); prog_mem[8'h35] = 8'h55;
    #4; check("t3_full_stall", ifc.cpu_stall, 1);
    @(negedge clk); ifc.bgrt = 1;
    #4; check("t3_accept", ifc.cpu_stall, 0); check("t3_pop", ifc.bus_we, 1);
    @(negedge clk);
    ifc.cpu_addr = 8'h36; ifc.cpu_wdata = 8'h66; ifc.bgrt = 0;
    exp_wr.push_back(16'h3666); prog_mem[8'h36] = 8'h66;
    #4; check("t3_still_full", ifc.cpu_stall, 1);
    @(negedge clk); ifc.bgrt = 1;
    #4; check("t3_accept2", ifc.cpu_stall, 0);
    @(negedge clk); ifc.cpu_we = 0;
    gmode = 2;
    repeat (5) idle();
    ifc.bgrt = 0; #4; check("t3_drained", ifc.breq, 0); @(negedge clk);
    // zero-wait load from empty FIFO
    poke = 1; poke_a = 8'h40; poke_d = 8'hAB; prog_mem[8'h40] = 8'hAB;
    @(negedge clk); poke = 0;
    gmode = 2;
    do_load(8'h40, wt, d);
    check("t4_waits", wt, 0); check("t4_data", d, 8'hAB);
    // load behind two stores to the same address
    gmode = 1;
    do_store(8'h20, 8'h11, wt);
    do_store(8'h20, 8'h22, wt);
`ifdef WBUF_FWD_EN
    do_load(8'h20, wt, d);
    check("t5_waits", wt, 0);
`else
    gmode = 2;
    do_load(8'h20, wt, d);
    check("t5_waits", wt, 2);
`endif
    check("t5_data", d, 8'h22);
    gmode = 2;
    repeat (3) idle();
    // reset on the first granted cycle discards queued stores
    gmode = 1;
    do_store(8'h50, 8'h01, wt);
    do_store(8'h51, 8'h02, wt);
    ifc.bgrt = 1; rst = 1;
    #4; check("t6_no_write", ifc.bus_we, 0);
    @(negedge clk); rst = 0; ifc.bgrt = 0;
    #4; check("t6_breq", ifc.breq, 0); check("t6_rdata", ifc.cpu_rdata, 0);
    exp_wr.delete();
    for (int i = 0; i < 256; i++) prog_mem[i] = sram[i];
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_store(8'(8'h58 + i), 8'(i + 1), wt);
      check("t6_empty_after", wt, 0);
    end
    gmode = 2;
    repeat (5) idle();
    // randomized traffic with varying grant density
    gmode = 0;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) gp = $urandom_range(20, 90);
      a = 8'(8'h10 + $urandom_range(0, 7));
      case ($urandom_range(0, 99)) inside
        [0:44]: do_store(a, 8'($urandom), wt);
        [45:79]: do_load(a, wt, d);
        default: idle();
      endcase
    end
    gmode = 2;
    repeat (8) idle();
    check("wr_left", exp_wr.size(), 0);
    check("ld_left", exp_ld.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
